// File: rtl/multiplier_seq_taint_v2_if.sv
// rtl/multiplier_seq_taint_v2_if.sv - operand/result bundle with taint shadows for the sequential multiplier
interface multiplier_seq_taint_v2_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   start_t;
    logic                   signed_mode;
    logic                   signed_mode_t;
    logic [WIDTH-1:0]       multiplier;
    logic [WIDTH-1:0]       multiplier_t;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplicand_t;
    logic                   ready;
    logic                   ready_t;
    logic                   done;
    logic                   done_t;
    logic [2*WIDTH-1:0]     product;
    logic [2*WIDTH-1:0]     product_t;

    modport master (
        output start, start_t, signed_mode, signed_mode_t,
               multiplier, multiplier_t, multiplicand, multiplicand_t,
        input  ready, ready_t, done, done_t, product, product_t
    );

    modport slave (
        input  start, start_t, signed_mode, signed_mode_t,
               multiplier, multiplier_t, multiplicand, multiplicand_t,
        output ready, ready_t, done, done_t, product, product_t
    );
endinterface

// File: rtl/multiplier_seq_taint_v2.sv
// rtl/multiplier_seq_taint_v2.sv - shift-add multiplier, signed/unsigned, optional early exit, bit-level taint
module multiplier_seq_taint_v2 #(
    parameter int WIDTH      = 32,
    parameter int EARLY_TERM = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    multiplier_seq_taint_v2_if.slave    bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [PW-1:0]     b_q, b_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              ct_q, ct_d;
    logic [PW-1:0]     pt_q, pt_d;
    logic [PW-1:0]     product_q, product_d;
    logic [PW-1:0]     product_t_q, product_t_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;

    logic [PW-1:0]     sum;
    logic              last_iter;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [PW-1:0]     tor_ext;
    logic [PW-1:0]     low_bit;
    logic              force_taint;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        ct_d        = ct_q;
        pt_d        = pt_q;
        product_d   = product_q;
        product_t_d = product_t_q;
        ready_d     = ready_q;
        done_d      = 1'b0;

        sum       = acc_q + (a_q[0] ? b_q : '0);
        last_iter = (cnt_q == CW'(WIDTH - 1)) ||
                    ((EARLY_TERM != 0) && ((a_q >> 1) == '0));

        // Magnitudes are taken as unsigned WIDTH-bit values so the most negative operand maps to 2^(WIDTH-1).
        a_mag = (bus.signed_mode && bus.multiplier[WIDTH-1])   ? -bus.multiplier   : bus.multiplier;
        b_mag = (bus.signed_mode && bus.multiplicand[WIDTH-1]) ? -bus.multiplicand : bus.multiplicand;

        // Any tainted operand bit taints every product bit at or above it (carries only move upward).
        tor_ext     = {{WIDTH{1'b0}}, bus.multiplier_t | bus.multiplicand_t};
        low_bit     = tor_ext & (-tor_ext);
        force_taint = bus.start_t
                    | ((EARLY_TERM != 0) && (|bus.multiplier_t))
                    | bus.signed_mode_t
                    | (bus.signed_mode & (bus.multiplier_t[WIDTH-1] | bus.multiplicand_t[WIDTH-1]));

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    a_d     = a_mag;
                    b_d     = {{WIDTH{1'b0}}, b_mag};
                    acc_d   = '0;
                    cnt_d   = '0;
                    neg_d   = bus.signed_mode & (bus.multiplier[WIDTH-1] ^ bus.multiplicand[WIDTH-1]);
                    ct_d    = bus.start_t | ((EARLY_TERM != 0) && (|bus.multiplier_t));
                    pt_d    = force_taint ? '1 : ~(low_bit - PW'(1));
                    ready_d = 1'b0;
                end
            end
            ST_RUN: begin
                acc_d = sum;
                a_d   = a_q >> 1;
                b_d   = b_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    product_d   = neg_q ? -sum : sum;
                    product_t_d = pt_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            ct_q        <= 1'b0;
            pt_q        <= '0;
            product_q   <= '0;
            product_t_q <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            ct_q        <= ct_d;
            pt_q        <= pt_d;
            product_q   <= product_d;
            product_t_q <= product_t_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.ready_t   = ct_q;
    assign bus.done      = done_q;
    assign bus.done_t    = ct_q;
    assign bus.product   = product_q;
    assign bus.product_t = product_t_q;
endmodule

// File: tb/tb_multiplier_seq_taint_v2.sv
// tb/tb_multiplier_seq_taint_v2.sv - table, directed and random checks of fixed and early-exit instances
module tb_multiplier_seq_taint_v2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       sel_s;
    logic       start_s, start_t_s, sm_s, sm_t_s;
    logic [7:0] a_s, at_s, b_s, bt_s;

    multiplier_seq_taint_v2_if #(.WIDTH(8)) fi();
    multiplier_seq_taint_v2_if #(.WIDTH(8)) ei();

    assign fi.start = start_s & ~sel_s;
    assign ei.start = start_s & sel_s;
    assign fi.start_t = start_t_s;         assign ei.start_t = start_t_s;
    assign fi.signed_mode = sm_s;          assign ei.signed_mode = sm_s;
    assign fi.signed_mode_t = sm_t_s;      assign ei.signed_mode_t = sm_t_s;
    assign fi.multiplier = a_s;            assign ei.multiplier = a_s;
    assign fi.multiplier_t = at_s;         assign ei.multiplier_t = at_s;
    assign fi.multiplicand = b_s;          assign ei.multiplicand = b_s;
    assign fi.multiplicand_t = bt_s;       assign ei.multiplicand_t = bt_s;

    multiplier_seq_taint_v2 #(.WIDTH(8), .EARLY_TERM(0)) u_fix (.clk(clk), .rst(rst), .bus(fi));
    multiplier_seq_taint_v2 #(.WIDTH(8), .EARLY_TERM(1)) u_early (.clk(clk), .rst(rst), .bus(ei));

    wire        ready_m   = sel_s ? ei.ready : fi.ready;
    wire        ready_t_m = sel_s ? ei.ready_t : fi.ready_t;
    wire        done_m    = sel_s ? ei.done : fi.done;
    wire        done_t_m  = sel_s ? ei.done_t : fi.done_t;
    wire [15:0] prod_m    = sel_s ? ei.product : fi.product;
    wire [15:0] prod_t_m  = sel_s ? ei.product_t : fi.product_t;

    typedef struct {
        logic        sel;
        logic        sm, sm_t, st_t;
        logic [7:0]  a, at, b, bt;
        logic [15:0] exp_prod, exp_pt;
        int          exp_lat;
        logic        exp_ct;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic over the operation's rules.
    function automatic vec_t mk(input logic sel, input logic sm, input logic smt, input logic stt,
                                input logic [7:0] a, input logic [7:0] at,
                                input logic [7:0] b, input logic [7:0] bt);
        vec_t v;
        int x, y, m, p;
        logic [7:0] tor;
        v.sel = sel; v.sm = sm; v.sm_t = smt; v.st_t = stt;
        v.a = a; v.at = at; v.b = b; v.bt = bt;
        x = a; y = b;
        if (sm && a[7]) x = x - 256;
        if (sm && b[7]) y = y - 256;
        v.exp_prod = 16'(x * y);
        if (!sel) v.exp_lat = 8;
        else begin
            m = (x < 0) ? -x : x;
            v.exp_lat = 1;
            for (int i = 0; i < 8; i++) if ((m >> i) & 1) v.exp_lat = i + 1;
        end
        v.exp_ct = stt | (sel & (at != 0));
        tor = at | bt;
        p = 16;
        for (int i = 7; i >= 0; i--) if (tor[i]) p = i;
        v.exp_pt = (p == 16) ? 16'h0000 : (16'hFFFF << p);
        if (v.exp_ct || smt || (sm && (at[7] || bt[7]))) v.exp_pt = 16'hFFFF;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int early_ready;
        @(negedge clk);
        sel_s = v.sel; sm_s = v.sm; sm_t_s = v.sm_t; start_t_s = v.st_t;
        a_s = v.a; at_s = v.at; b_s = v.b; bt_s = v.bt;
        start_s = 1'b1;
        check({tag, "_ready_idle"}, 32'(ready_m), 32'd1);
        @(posedge clk);
        @(negedge clk);
        start_s = 1'b0;
        check({tag, "_ready_drop"}, 32'(ready_m), 32'd0);
        lat = 0;
        early_ready = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_m) begin lat = n; break; end
            if (ready_m) early_ready++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_ready_run"}, 32'(early_ready), 32'd0);
        check({tag, "_ready_in_done"}, 32'(ready_m), 32'd0);
        check({tag, "_product"}, 32'(prod_m), 32'(v.exp_prod));
        check({tag, "_product_t"}, 32'(prod_t_m), 32'(v.exp_pt));
        check({tag, "_done_t"}, 32'(done_t_m), 32'(v.exp_ct));
        check({tag, "_ready_t"}, 32'(ready_t_m), 32'(v.exp_ct));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done_m), 32'd0);
        check({tag, "_ready_back"}, 32'(ready_m), 32'd1);
    endtask

    vec_t tbl[12];
    int   ndone;

    initial begin
        sel_s = 0; start_s = 0; start_t_s = 0; sm_s = 0; sm_t_s = 0;
        a_s = 0; at_s = 0; b_s = 0; bt_s = 0;
        tbl[0]  = '{0, 0, 0, 0, 8'd13, 8'h00, 8'd11, 8'h00, 16'h008F, 16'h0000, 8, 0};
        tbl[1]  = '{0, 1, 0, 0, 8'hFD, 8'h00, 8'h05, 8'h00, 16'hFFF1, 16'h0000, 8, 0};
        tbl[2]  = '{0, 1, 0, 0, 8'h80, 8'h00, 8'h80, 8'h00, 16'h4000, 16'h0000, 8, 0};
        tbl[3]  = '{0, 1, 0, 0, 8'h7F, 8'h00, 8'h80, 8'h00, 16'hC080, 16'h0000, 8, 0};
        tbl[4]  = '{0, 0, 0, 0, 8'd13, 8'h04, 8'd11, 8'h00, 16'h008F, 16'hFFFC, 8, 0};
        tbl[5]  = '{0, 0, 0, 0, 8'd13, 8'h00, 8'd11, 8'h80, 16'h008F, 16'hFF80, 8, 0};
        tbl[6]  = '{0, 1, 0, 0, 8'd13, 8'h00, 8'd11, 8'h80, 16'h008F, 16'hFFFF, 8, 0};
        tbl[7]  = '{1, 0, 0, 0, 8'd3,  8'h00, 8'd11, 8'h00, 16'h0021, 16'h0000, 2, 0};
        tbl[8]  = '{1, 0, 0, 0, 8'd3,  8'h01, 8'd11, 8'h00, 16'h0021, 16'hFFFF, 2, 1};
        tbl[9]  = '{1, 0, 0, 0, 8'd0,  8'h00, 8'h55, 8'h00, 16'h0000, 16'h0000, 1, 0};
        tbl[10] = '{0, 0, 0, 1, 8'd2,  8'h00, 8'd3,  8'h00, 16'h0006, 16'hFFFF, 8, 1};
        tbl[11] = '{1, 1, 0, 0, 8'hFF, 8'h00, 8'd5,  8'h00, 16'hFFFB, 16'h0000, 1, 0};

        #12;
        check("rst_ready", 32'(fi.ready), 32'd1);
        check("rst_done", 32'(fi.done), 32'd0);
        check("rst_product", 32'(fi.product), 32'd0);
        check("rst_product_t", 32'(fi.product_t), 32'd0);
        check("rst_ready_t", 32'(fi.ready_t), 32'd0);
        check("rst_done_t", 32'(fi.done_t), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Start pulse during RUN must be ignored and not queued.
        @(negedge clk);
        sel_s = 0; sm_s = 0; sm_t_s = 0; start_t_s = 0;
        a_s = 8'd13; at_s = 0; b_s = 8'd11; bt_s = 0; start_s = 1;
        @(posedge clk);
        @(negedge clk);
        start_s = 0;
        ndone = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 2) begin a_s = 8'd2; b_s = 8'd2; start_s = 1; end
            if (n == 3) start_s = 0;
            if (done_m) begin
                ndone++;
                check("ign_done_cycle", 32'(n), 32'd8);
                check("ign_product", 32'(prod_m), 32'h008F);
            end
        end
        check("ign_done_count", 32'(ndone), 32'd1);
        check("ign_idle", 32'(ready_m), 32'd1);
        run_vec(mk(0, 0, 0, 0, 8'd2, 8'h00, 8'd2, 8'h00), "ign_second");

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        a_s = 8'd13; b_s = 8'd11; start_t_s = 1; start_s = 1;
        @(posedge clk);
        @(negedge clk);
        start_s = 0; start_t_s = 0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(fi.ready), 32'd1);
        check("mid_rst_done", 32'(fi.done), 32'd0);
        check("mid_rst_product", 32'(fi.product), 32'd0);
        check("mid_rst_product_t", 32'(fi.product_t), 32'd0);
        check("mid_rst_ready_t", 32'(fi.ready_t), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (fi.done) ndone++;
        end
        check("mid_rst_no_done", 32'(ndone), 32'd0);
        run_vec(mk(0, 0, 0, 0, 8'd5, 8'h00, 8'd7, 8'h00), "post_rst");

        // Randomized operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            logic [7:0] ra, rb, rat, rbt;
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rat = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            rbt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            if (i % 5 == 0) ra = ra >> $urandom_range(0, 7);
            run_vec(mk(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 7) == 0), ra, rat, rb, rbt),
                    $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
